bsg_xor_descrambler: RTL and testbench
======================================

# bsg_xor_descrambler

Additive (synchronous) stream descrambler: recovers payload words by XOR-ing each accepted input word with a keystream generated by a Galois LFSR that runs in lockstep with the link-side scrambler. It sits on the receive side of a scrambled link, after word alignment and before the consumer. It uses a valid/ready input and a valid/yumi output with one registered output stage. A frame-sync input reloads the LFSR so both link ends realign.

## Interface
- `width_p`, 16: data, LFSR and keystream width in bits.
- `taps_p`, `16'hB400`: Galois feedback mask, default x^16+x^14+x^13+x^11+1; `width_p` bits wide.
- `seed_p`, `16'hACE1`: LFSR reset value. Also substituted for a zero `seed_i`. Must be nonzero.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `v_i`  in  1  input word valid.
- `data_i`  in  `width_p`  scrambled input word.
- `ready_o`  out  1  input can be accepted this cycle.
- `sync_i`  in  1  qualifies the word accepted this cycle as the first word of a frame.
- `seed_i`  in  `width_p`  LFSR seed used when `sync_i` qualifies an accepted word.
- `v_o`  out  1  output word valid.
- `data_o`  out  `width_p`  descrambled word.
- `yumi_i`  in  1  consumer takes `data_o` this cycle; legal only when `v_o`=1.
- `bypass_i`  in  1  present only with `BSG_XOR_DESCRAMBLER_BYPASS_EN`.

## Operation
- **Registers:**
  - `lfsr_r` (`width_p`).
  - Output register `data_r`/`v_r`.
- **Accept:** `accept = v_i & ready_o`. `ready_o = ~v_r | yumi_i`, so one word per cycle at full throughput.
- **Keystream for the accepted word:**
  - `ks = (sync_i && seed_i != 0) ? seed_i : (sync_i ? seed_p : lfsr_r)`.
  - `sync_i` is ignored when there is no accept.
- **Output on accept:** `data_r <= data_i ^ ks` and `v_r <= 1`.
- **Output without accept:** if `yumi_i`=1, `v_r <= 0`; otherwise hold.
- **LFSR advance on accept:** `lfsr_r <= next(ks)`, where `next(s) = s[0] ? (s >> 1) ^ taps_p : s >> 1`.
- **LFSR hold:** `lfsr_r` does not change without an accept. Backpressure and idle cycles never advance the keystream.
- **Zero state:** a zero state is unreachable. The zero-seed substitution guarantees this.
- **`sync_i` with `v_i`=0 or `ready_o`=0:** no effect. The producer holds `sync_i` with its word until the word is accepted.

## Timing
- **Reset:** asynchronous. Forces `lfsr_r`=`seed_p`, `v_o`=0, `data_o`=0. `ready_o` is 1 while `reset_i` is high, and no accept occurs during reset.
- **Latency:** 1 cycle. A word accepted at edge N appears on `data_o` with `v_o`=1 after edge N and holds until the edge where `yumi_i`=1.
- **Accept and yumi in the same cycle:** the new word replaces the old one, and `v_o` stays 1.
- **Reset mid-stream:** the output word is discarded (`v_o`=0). The keystream restarts at `seed_p`, so the far end must resync with `sync_i`.
- **Combinational paths:**
  - `ready_o` depends combinationally on `yumi_i`.
  - No combinational path from `data_i` to `data_o`.

## Configuration
- **Macro:** `BSG_XOR_DESCRAMBLER_BYPASS_EN`.
- **Defined:**
  - Port `bypass_i` exists.
  - When an accepted word has `bypass_i`=1: `data_r <= data_i`, and `lfsr_r` holds.
  - `sync_i` still reloads the LFSR: `lfsr_r <= next(seed)` is skipped, and the loaded value is the seed itself.
- **Undefined:** no `bypass_i` port. Every accepted word is descrambled.

## Test plan
- **Reset, then scrambled zeros:** after reset, send `data_i`=`16'h0000` twice with `yumi_i`=1. Expect `data_o`=`16'hACE1`, then `16'hE270`.
- **Backpressure:** with `yumi_i`=0 for 5 cycles and `v_i`=1, expect:
  - `ready_o`=0 after the first accept.
  - `data_o` stable.
  - The next word after yumi is descrambled with `16'hE270`.
- **Sync mid-stream:** at word 3, `sync_i`=1 with `seed_i`=`16'h1234` and `data_i`=`16'h1234`. Expect:
  - `data_o`=`16'h0000`.
  - The following word uses `next(16'h1234)`=`16'h091A`.
- **Zero seed:** `sync_i`=1 with `seed_i`=0 and `data_i`=0. Expect `data_o`=`16'hACE1`.
- **Random round trip:** 10k random payloads through a reference scrambler model with random `v_i`/`yumi_i` stalls and random syncs. Expect bit-exact payload recovery and no lost or duplicated words.
- **Reset asserted while `v_o`=1:** expect `v_o`=0 and `data_o`=0 immediately, with no clock edge required. After release, the first word is descrambled with `16'hACE1`.

Source files
------------

// File: rtl/bsg_xor_descrambler.sv
// bsg_xor_descrambler: additive descrambler, Galois LFSR keystream.
// Optional bypass_i port under BSG_XOR_DESCRAMBLER_BYPASS_EN.
module bsg_xor_descrambler #(
  parameter int unsigned        width_p = 16,
  parameter logic [width_p-1:0] taps_p  = 16'hB400,
  parameter logic [width_p-1:0] seed_p  = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  input  logic               sync_i,
  input  logic [width_p-1:0] seed_i,
`ifdef BSG_XOR_DESCRAMBLER_BYPASS_EN
  input  logic               bypass_i,
`endif
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] lfsr_q, lfsr_d;
  logic [width_p-1:0] data_q, data_d;
  logic               v_q, v_d;
  logic [width_p-1:0] seed_eff;
  logic [width_p-1:0] ks;
  logic [width_p-1:0] ks_next;
  logic               accept;

  assign ready_o = ~v_q | yumi_i;
  assign accept  = v_i & ready_o;
  assign v_o     = v_q;
  assign data_o  = data_q;

  // Keystream select: a zero seed would lock the LFSR, so swap in seed_p.
  always_comb begin
    seed_eff = (seed_i != '0) ? seed_i : seed_p;
    ks       = sync_i ? seed_eff : lfsr_q;
    ks_next  = ks >> 1;
    if (ks[0])
      ks_next = (ks >> 1) ^ taps_p;
  end

  // Next state of output stage and LFSR; nothing advances without accept.
  always_comb begin
    lfsr_d = lfsr_q;
    data_d = data_q;
    v_d    = v_q;
    if (accept) begin
      v_d = 1'b1;
`ifdef BSG_XOR_DESCRAMBLER_BYPASS_EN
      if (bypass_i) begin
        data_d = data_i;
        if (sync_i)
          lfsr_d = seed_eff;
      end else begin
        data_d = data_i ^ ks;
        lfsr_d = ks_next;
      end
`else
      data_d = data_i ^ ks;
      lfsr_d = ks_next;
`endif
    end else if (yumi_i) begin
      v_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_q <= seed_p;
      data_q <= '0;
      v_q    <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      data_q <= data_d;
      v_q    <= v_d;
    end
  end

endmodule

// File: tb/tb_bsg_xor_descrambler.sv
// tb_bsg_xor_descrambler: directed and random round-trip bench.
// Model tracks the link keystream and the expected output word.
module tb_bsg_xor_descrambler;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk;
  logic        reset_i;
  logic        v_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic        sync_i;
  logic [15:0] seed_i;
  logic        v_o;
  logic [15:0] data_o;
  logic        yumi_i;

  int checks;
  int errors;

  logic [15:0] ks_state;
  logic        ev;
  logic [15:0] ed;
  logic        acc_last;
  logic [15:0] pq[$];

  bsg_xor_descrambler dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .sync_i  (sync_i),
    .seed_i  (seed_i),
`ifdef BSG_XOR_DESCRAMBLER_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [15:0] key_for(
    input logic sy, input logic [15:0] sd);
    if (!sy) return ks_state;
    return (sd != 16'h0) ? sd : SEED;
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    ks_state = SEED;
    ev       = 1'b0;
    ed       = 16'h0;
    pq.delete();
  endtask

  // One clock: drive, check ready/consumption, advance model, check outputs.
  task automatic cyc(input logic v, input logic [15:0] d,
                     input logic sy, input logic [15:0] sd,
                     input logic y);
    logic [15:0] k;
    logic        yy;
    k  = key_for(sy, sd);
    yy = y & ev;
    v_i    = v;
    data_i = d;
    sync_i = sy;
    seed_i = sd;
    yumi_i = yy;
    #1;
    chk("ready", {15'h0, ready_o}, {15'h0, (~ev | yy)});
    if (yy && pq.size() > 0)
      chk("payload", data_o, pq.pop_front());
    acc_last = v & (~ev | yy);
    @(posedge clk);
    if (acc_last) begin
      ev       = 1'b1;
      ed       = d ^ k;
      ks_state = nxt(k);
    end else if (yy) begin
      ev = 1'b0;
    end
    @(negedge clk);
    chk("v_o", {15'h0, v_o}, {15'h0, ev});
    if (ev)
      chk("data_o", data_o, ed);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] sd;
    logic        sy;
    logic        y;
    logic        vv;
    int          guard;
    checks   = 0;
    errors   = 0;
    acc_last = 1'b0;
    v_i      = 1'b0;
    data_i   = 16'h0;
    sync_i   = 1'b0;
    seed_i   = 16'h0;
    yumi_i   = 1'b0;
    reset_i  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    chk("rst_v", {15'h0, v_o}, 16'h0);
    chk("rst_data", data_o, 16'h0);
    chk("rst_ready", {15'h0, ready_o}, 16'h1);

    cyc(1, 16'h0000, 0, 16'h0, 1);
    chk("zero_w0", data_o, 16'hACE1);
    cyc(1, 16'h0000, 0, 16'h0, 1);
    chk("zero_w1", data_o, 16'hE270);
    cyc(1, 16'h1234, 1, 16'h1234, 1);
    chk("sync_w", data_o, 16'h0000);
    cyc(1, 16'h0000, 0, 16'h0, 1);
    chk("sync_next", data_o, 16'h091A);
    cyc(1, 16'h0000, 1, 16'h0000, 1);
    chk("zero_seed", data_o, 16'hACE1);
    cyc(0, 16'h0, 0, 16'h0, 1);

    do_reset();
    cyc(1, 16'h0000, 0, 16'h0, 0);
    chk("bp_first", data_o, 16'hACE1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h0000, 1, 16'h5555, 0);
      chk("bp_ready", {15'h0, ready_o}, 16'h0);
      chk("bp_hold", data_o, 16'hACE1);
    end
    cyc(1, 16'h0000, 0, 16'h0, 1);
    chk("bp_next", data_o, 16'hE270);

    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_v", {15'h0, v_o}, 16'h0);
    chk("arst_data", data_o, 16'h0);
    chk("arst_ready", {15'h0, ready_o}, 16'h1);
    @(negedge clk);
    reset_i = 1'b0;
    model_reset();
    cyc(1, 16'h0000, 0, 16'h0, 1);
    chk("arst_first", data_o, 16'hACE1);
    cyc(0, 16'h0, 0, 16'h0, 1);
    pq.delete();

    for (int n = 0; n < 10000; n++) begin
      p  = 16'($urandom);
      sy = ($urandom_range(0, 15) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 16'h0
                                       : 16'($urandom);
      guard = 0;
      acc_last = 1'b0;
      while (!acc_last) begin
        vv = ($urandom_range(0, 3) != 0);
        y  = ($urandom_range(0, 2) != 0);
        cyc(vv, p ^ key_for(sy, sd), sy, sd, y);
        if (acc_last) pq.push_back(p);
        guard++;
        if (guard > 200) begin
          chk("accept_timeout", 16'h0, 16'h1);
          acc_last = 1'b1;
        end
      end
    end
    guard = 0;
    while (ev && guard < 10) begin
      cyc(0, 16'h0, 0, 16'h0, 1);
      guard++;
    end
    chk("lost_words", 16'(pq.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
